tlc_phase_arbiter: RTL and testbench
====================================

# tlc_phase_arbiter

Multi-approach phase arbiter for a signalised intersection. It shares the single intersection resource among `N_APP` approaches. Each approach has a vehicle sensor and a pedestrian push-button. The block grants green to one approach at a time, enforcing minimum and maximum green, fixed yellow and all-red clearance times, and round-robin fairness. It generalises the two-road main/side controller to N approaches, with approach 0 as the default (main-road) phase.

## Interface
Parameters:
- `N_APP`, 4: number of approaches (2..8).
- `CW`, 8: width of the phase timer.
- `T_MIN_GREEN`, 5: minimum green, in ticks.
- `T_MAX_GREEN`, 20: maximum green while others wait, in ticks.
- `T_YELLOW`, 3: yellow duration, in ticks.
- `T_ALLRED`, 1: all-red clearance, in ticks.
- `T_WALK`, 4: pedestrian walk duration, in ticks.
- Constraints: all timing parameters ≥ 1; `T_WALK ≤ T_MIN_GREEN ≤ T_MAX_GREEN < 2^CW`.

Ports:
- `clock`, in, 1: the only clock.
- `reset`, in, 1: synchronous, active-high.
- `tick`, in, 1: one-cycle timebase pulse (nominally 1 s). All timers advance only on `tick`.
- `sensor`, in, `N_APP`: vehicle present per approach, level.
- `ped_btn`, in, `N_APP`: pedestrian button per approach, one-cycle pulses.
- `lights`, out, `3*N_APP`: per-approach lamp; approach i occupies bits [3i+2:3i]. Encoding: red = 100, yellow = 010, green = 001.
- `walk`, out, `N_APP`: pedestrian WALK per approach.
- `active`, out, `$clog2(N_APP)`: index of the approach currently owning the phase.
- `phase`, out, 2: 00 GREEN, 01 YELLOW, 10 ALLRED.

## Operation
- **Reset values:** `phase` = GREEN, `active` = 0, timer = 0, round-robin pointer = 0, all ped latches cleared, `walk` = 0. `lights` shows approach 0 green and all others red.
- **Ped latches:**
  - A `ped_btn[i]` pulse sets `ped_pend[i]`.
  - The latch clears only when approach i is granted green (ALLRED→GREEN with next = i).
  - A pulse in the same cycle as that grant is absorbed into the grant; the latch stays clear.
- **Pending vector:** `pend = sensor | ped_pend`. "Others pending" means `pend` with the active bit masked off.
- **Timer:** counts ticks elapsed in the current phase and saturates at `2^CW-1`. It clears on every phase change.
- **GREEN:**
  - On a tick cycle, the block exits to YELLOW when all of the following hold:
    - (timer+1) ≥ `T_MIN_GREEN`;
    - others are pending;
    - `sensor[active]` is low, or (timer+1) ≥ `T_MAX_GREEN`.
  - With no other requests, green holds indefinitely, regardless of the timer.
- **Next selection:**
  - Computed at the GREEN→YELLOW edge as the first pending approach searching `active+1, active+2, …` modulo `N_APP`.
  - Stored in `next_q` and frozen through YELLOW and ALLRED. Later requests do not change it.
- **YELLOW:** active approach shows yellow. On the tick where timer+1 == `T_YELLOW`, the block moves to ALLRED.
- **ALLRED:** all approaches show red. On the tick where timer+1 == `T_ALLRED`, the block moves to GREEN with `active` = `next_q`.
- **Walk:**
  - At a grant, if `ped_pend[next_q]` (or a simultaneous pulse on it) is set, `walk[active]` asserts for exactly `T_WALK` ticks of GREEN.
  - `walk` is never asserted outside GREEN. Only the active bit can be 1.
- **Lights:** the active approach shows green/yellow/red according to phase. All other approaches show red. At most one approach is ever non-red.

## Timing
- State, timer, `active`, `next_q` and the latches are registered.
- `lights`, `walk` and `phase` are a pure decode of registered state. They change in the cycle after the edge on which the triggering tick was sampled.
- Non-tick cycles never change phase or timer. Latches still capture `ped_btn`.
- **Durations in ticks:**
  - YELLOW = `T_YELLOW` exactly.
  - ALLRED = `T_ALLRED` exactly.
  - GREEN ≥ `T_MIN_GREEN`. GREEN ≤ `T_MAX_GREEN` whenever others are pending continuously.
- `reset` asserted mid-phase returns the block to its reset values on the next edge. Reset has priority over `tick`.
- `sensor` is assumed synchronous to `clock`. Synchronisers live upstream.

## Structure
- Package `tlc_pkg`:
  - light encodings `LIGHT_RED`, `LIGHT_YELLOW`, `LIGHT_GREEN`;
  - phase enum `PH_GREEN`, `PH_YELLOW`, `PH_ALLRED`;
  - a `tlc_light_t` 3-bit typedef.
- Sub-module `tlc_rr_pick`: combinational round-robin picker. Inputs are a pending vector and a start index. Outputs are a `valid` flag and the selected index. It is instantiated once for next selection.

## Test plan
Defaults: `N_APP`=4, `T_MIN_GREEN`=5, `T_MAX_GREEN`=20, `T_YELLOW`=3, `T_ALLRED`=1, `T_WALK`=4, `tick` every 4 clocks.
- **Reset:** release reset with no requests and run 100 ticks → `lights` = {100,100,100,001}, `phase` = GREEN throughout, `walk` = 0.
- **Gap-out:** at tick 2, `sensor` = 0100 and `sensor[0]` = 0 → YELLOW after tick 5, ALLRED after tick 8, then GREEN with `active` = 2 after tick 9.
- **Max-out:** `sensor` = 1111 held continuously → approach 0 green for 20 ticks, then rotation 1→2→3→0, each green lasting 20 ticks, with 3 yellow and 1 all-red tick between.
- **Ped:** `ped_btn[3]` pulse while approach 1 is green with `sensor[1]` = 0 past min green → `active` = 3 and `walk` = 1000 for 4 ticks. `ped_pend[3]` clears at the grant.
- **Frozen next:** `sensor[1]` rises during YELLOW toward next = 3 → grant still goes to 3. Approach 1 is served at the following rotation.
- **Mid-phase reset:** assert `reset` for 1 cycle during ALLRED → next cycle shows `active` = 0, GREEN, timer 0, latches cleared.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared types for the multi-approach traffic phase arbiter.
// Lamp encodings and the phase enum used by the top and the picker.
package tlc_pkg;

    typedef logic [2:0] tlc_light_t;

    localparam tlc_light_t LIGHT_RED    = 3'b100;
    localparam tlc_light_t LIGHT_YELLOW = 3'b010;
    localparam tlc_light_t LIGHT_GREEN  = 3'b001;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'b00,
        PH_YELLOW = 2'b01,
        PH_ALLRED = 2'b10
    } tlc_phase_t;

endpackage

// File: rtl/tlc_rr_pick.sv
// Combinational round-robin picker: first set bit of pend
// searching start, start+1, ... modulo N.
module tlc_rr_pick
    import tlc_pkg::*;
#(
    parameter int N  = 4,
    parameter int AW = $clog2(N)
) (
    input  logic [N-1:0]  pend,
    input  logic [AW-1:0] start,
    output logic          valid,
    output logic [AW-1:0] idx
);

    int k;

    always_comb begin
        valid = 1'b0;
        idx   = start;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            k = int'(start) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (!valid && pend[k]) begin
                valid = 1'b1;
                idx   = AW'(k);
            end
        end
    end

endmodule

// File: rtl/tlc_phase_arbiter.sv
// N-approach signal phase arbiter: min/max green, fixed yellow and
// all-red, round-robin service and pedestrian walk per approach.
module tlc_phase_arbiter
    import tlc_pkg::*;
#(
    parameter int N_APP       = 4,
    parameter int CW          = 8,
    parameter int T_MIN_GREEN = 5,
    parameter int T_MAX_GREEN = 20,
    parameter int T_YELLOW    = 3,
    parameter int T_ALLRED    = 1,
    parameter int T_WALK      = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     tick,
    input  logic [N_APP-1:0]         sensor,
    input  logic [N_APP-1:0]         ped_btn,
    output logic [3*N_APP-1:0]       lights,
    output logic [N_APP-1:0]         walk,
    output logic [$clog2(N_APP)-1:0] active,
    output logic [1:0]               phase
);

    localparam int AW = $clog2(N_APP);

    tlc_phase_t       state_q, state_d;
    logic [CW-1:0]    timer_q, timer_d;
    logic [AW-1:0]    active_q, active_d;
    logic [AW-1:0]    next_q, next_d;
    logic [N_APP-1:0] ped_pend_q, ped_pend_d;
    logic             walk_q, walk_d;

    logic [N_APP-1:0] pend, others;
    logic [AW-1:0]    start_idx, pick_idx;
    logic             pick_valid;
    logic [CW:0]      t_inc;

    always_comb begin
        pend             = sensor | ped_pend_q;
        others           = pend;
        others[active_q] = 1'b0;
        if (active_q == AW'(N_APP - 1)) begin
            start_idx = '0;
        end else begin
            start_idx = active_q + 1'b1;
        end
    end

    tlc_rr_pick #(
        .N  (N_APP),
        .AW (AW)
    ) u_pick (
        .pend  (others),
        .start (start_idx),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        active_d   = active_q;
        next_d     = next_q;
        ped_pend_d = ped_pend_q | ped_btn;
        walk_d     = walk_q;
        t_inc      = {1'b0, timer_q} + 1'b1;
        if (tick) begin
            if (timer_q != '1) begin
                timer_d = timer_q + 1'b1;
            end
            case (state_q)
                PH_GREEN: begin
                    if (walk_q && t_inc >= (CW+1)'(T_WALK)) begin
                        walk_d = 1'b0;
                    end
                    // pick_valid doubles as "others pending"
                    if (t_inc >= (CW+1)'(T_MIN_GREEN) && pick_valid &&
                        (!sensor[active_q] ||
                         t_inc >= (CW+1)'(T_MAX_GREEN))) begin
                        state_d = PH_YELLOW;
                        timer_d = '0;
                        next_d  = pick_idx;
                        walk_d  = 1'b0;
                    end
                end
                PH_YELLOW: begin
                    if (t_inc >= (CW+1)'(T_YELLOW)) begin
                        state_d = PH_ALLRED;
                        timer_d = '0;
                    end
                end
                PH_ALLRED: begin
                    if (t_inc >= (CW+1)'(T_ALLRED)) begin
                        state_d            = PH_GREEN;
                        timer_d            = '0;
                        active_d           = next_q;
                        walk_d             = ped_pend_q[next_q] |
                                             ped_btn[next_q];
                        ped_pend_d[next_q] = 1'b0;
                    end
                end
                default: begin
                    state_d = PH_GREEN;
                    timer_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= PH_GREEN;
            timer_q    <= '0;
            active_q   <= '0;
            next_q     <= '0;
            ped_pend_q <= '0;
            walk_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            active_q   <= active_d;
            next_q     <= next_d;
            ped_pend_q <= ped_pend_d;
            walk_q     <= walk_d;
        end
    end

    always_comb begin
        lights = '0;
        walk   = '0;
        for (int i = 0; i < N_APP; i++) begin
            lights[3*i +: 3] = LIGHT_RED;
            if (active_q == AW'(i)) begin
                case (state_q)
                    PH_GREEN:  lights[3*i +: 3] = LIGHT_GREEN;
                    PH_YELLOW: lights[3*i +: 3] = LIGHT_YELLOW;
                    default:   lights[3*i +: 3] = LIGHT_RED;
                endcase
                walk[i] = walk_q && (state_q == PH_GREEN);
            end
        end
        phase  = state_q;
        active = active_q;
    end

endmodule

// File: tb/tb_tlc_phase_arbiter.sv
// Directed bench for tlc_phase_arbiter with default parameters;
// one tick every 4 clocks, outputs sampled on the falling edge.
module tb_tlc_phase_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic [3:0]  sensor = '0;
    logic [3:0]  ped_btn = '0;
    logic [11:0] lights;
    logic [3:0]  walk;
    logic [1:0]  active;
    logic [1:0]  phase;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [11:0] L_ALLRED = 12'h924;
    localparam logic [11:0] L_G0     = 12'h921;
    localparam logic [11:0] L_Y0     = 12'h922;
    localparam logic [11:0] L_G1     = 12'h90C;
    localparam logic [11:0] L_G2     = 12'h864;
    localparam logic [11:0] L_G3     = 12'h324;

    tlc_phase_arbiter dut (
        .clock   (clock),
        .reset   (reset),
        .tick    (tick),
        .sensor  (sensor),
        .ped_btn (ped_btn),
        .lights  (lights),
        .walk    (walk),
        .active  (active),
        .phase   (phase)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_tick();
        @(negedge clock) tick = 1'b1;
        @(negedge clock) tick = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic do_reset();
        @(negedge clock) reset = 1'b1;
        @(negedge clock) reset = 1'b0;
    endtask

    task automatic pulse_ped(input logic [3:0] b);
        @(negedge clock) ped_btn = b;
        @(negedge clock) ped_btn = '0;
    endtask

    initial begin
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_lights", lights, L_G0);
        chk("rst_phase", phase, 2'b00);
        chk("rst_active", active, 0);
        chk("rst_walk", walk, 0);

        for (int t = 0; t < 100; t++) begin
            do_tick();
            chk("idle_lights", lights, L_G0);
            chk("idle_phase", phase, 2'b00);
            chk("idle_walk", walk, 0);
        end

        // gap-out to approach 2
        do_reset();
        do_tick();
        sensor = 4'b0100;
        run_ticks(3);
        chk("gap_t4_phase", phase, 2'b00);
        do_tick();
        chk("gap_t5_phase", phase, 2'b01);
        chk("gap_t5_lights", lights, L_Y0);
        run_ticks(2);
        chk("gap_t7_phase", phase, 2'b01);
        do_tick();
        chk("gap_t8_phase", phase, 2'b10);
        chk("gap_t8_lights", lights, L_ALLRED);
        do_tick();
        chk("gap_t9_phase", phase, 2'b00);
        chk("gap_t9_active", active, 2);
        chk("gap_t9_lights", lights, L_G2);
        sensor = '0;
        run_ticks(30);
        chk("gap_hold_active", active, 2);
        chk("gap_hold_phase", phase, 2'b00);

        // max-out rotation
        do_reset();
        sensor = 4'b1111;
        for (int k = 1; k <= 4; k++) begin
            run_ticks(19);
            chk("max_g19_phase", phase, 2'b00);
            chk("max_g19_active", active, 32'((k - 1) % 4));
            do_tick();
            chk("max_g20_phase", phase, 2'b01);
            run_ticks(3);
            chk("max_ar_phase", phase, 2'b10);
            do_tick();
            chk("max_next_phase", phase, 2'b00);
            chk("max_next_active", active, 32'(k % 4));
        end
        sensor = '0;

        // ped request while approach 1 idles past min green
        do_reset();
        sensor = 4'b0010;
        run_ticks(9);
        chk("ped_g1_active", active, 1);
        chk("ped_g1_lights", lights, L_G1);
        chk("ped_g1_walk", walk, 0);
        sensor = '0;
        run_ticks(5);
        chk("ped_hold_phase", phase, 2'b00);
        pulse_ped(4'b1000);
        do_tick();
        chk("ped_yel_phase", phase, 2'b01);
        run_ticks(3);
        chk("ped_ar_phase", phase, 2'b10);
        do_tick();
        chk("ped_g3_active", active, 3);
        chk("ped_g3_lights", lights, L_G3);
        chk("ped_walk_on", walk, 4'b1000);
        run_ticks(3);
        chk("ped_walk_t3", walk, 4'b1000);
        do_tick();
        chk("ped_walk_t4", walk, 0);

        // ped latch for 3 must be clear: approach 0 keeps green
        sensor = 4'b0001;
        do_tick();
        chk("ped_to0_phase", phase, 2'b01);
        run_ticks(4);
        chk("ped_to0_active", active, 0);
        chk("ped_to0_grn", phase, 2'b00);
        sensor = '0;
        run_ticks(10);
        chk("ped_clr_active", active, 0);
        chk("ped_clr_phase", phase, 2'b00);

        // frozen next: sensor[1] rises during yellow toward 3
        sensor = 4'b1000;
        do_tick();
        chk("frz_yel_phase", phase, 2'b01);
        sensor = 4'b1010;
        run_ticks(4);
        chk("frz_grant_active", active, 3);
        chk("frz_grant_phase", phase, 2'b00);
        sensor = 4'b0010;
        run_ticks(4);
        chk("frz_min_phase", phase, 2'b00);
        do_tick();
        chk("frz_yel2_phase", phase, 2'b01);
        run_ticks(4);
        chk("frz_serve1_active", active, 1);
        chk("frz_serve1_lights", lights, L_G1);

        // reset during all-red, coincident with a granting tick
        sensor = '0;
        run_ticks(5);
        pulse_ped(4'b1000);
        do_tick();
        run_ticks(3);
        chk("mid_ar_phase", phase, 2'b10);
        @(negedge clock);
        reset = 1'b1;
        tick  = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        tick  = 1'b0;
        chk("mid_rst_active", active, 0);
        chk("mid_rst_phase", phase, 2'b00);
        chk("mid_rst_lights", lights, L_G0);
        chk("mid_rst_walk", walk, 0);
        run_ticks(10);
        chk("mid_latch_active", active, 0);
        chk("mid_latch_phase", phase, 2'b00);

        // timer restarted at 0: gap-out exactly on tick 5
        do_reset();
        sensor = 4'b0100;
        run_ticks(4);
        chk("mid_t4_phase", phase, 2'b00);
        do_tick();
        chk("mid_t5_phase", phase, 2'b01);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
